// File: rtl/shift_issue_ctrl.sv
// Issue/response controller for the sequential shifter: accepts one request, pulses start, waits for done or timeout, returns the result.
// Latency: accept edge + 1 ISSUE + N WAIT + 1 RESP; only one op in flight, so req_ready stays low until the response handshake completes.
module shift_issue_ctrl #(
    parameter  int TIMEOUT = 16,
    localparam int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_ctrl,
    input  logic [2:0] req_amt,
    input  logic [7:0] req_data,
    output logic       sh_start,
    output logic [1:0] sh_ctrl,
    output logic [2:0] sh_amt,
    output logic [7:0] sh_data,
    input  logic [7:0] sh_result,
    input  logic       sh_done,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sh_ctrl_q, sh_ctrl_d;
    logic [2:0]       sh_amt_q, sh_amt_d;
    logic [7:0]       sh_data_q, sh_data_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       op_count_q, op_count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sh_ctrl_q     <= '0;
            sh_amt_q      <= '0;
            sh_data_q     <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            timer_q       <= '0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            sh_ctrl_q     <= sh_ctrl_d;
            sh_amt_q      <= sh_amt_d;
            sh_data_q     <= sh_data_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            timer_q       <= timer_d;
            op_count_q    <= op_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sh_ctrl_d     = sh_ctrl_q;
        sh_amt_d      = sh_amt_q;
        sh_data_d     = sh_data_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_d       = timer_q;
        op_count_d    = op_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sh_ctrl_d = req_ctrl;
                    sh_amt_d  = req_amt;
                    sh_data_d = req_data;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // done takes priority over an expiring timer in the same cycle
                if (sh_done) begin
                    rsp_data_d    = sh_result;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_data_d    = sh_data_q;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from the state flop so reset drops them without waiting for an edge.
    assign req_ready   = (state_q == IDLE);
    assign sh_start    = (state_q == ISSUE);
    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign sh_ctrl     = sh_ctrl_q;
    assign sh_amt      = sh_amt_q;
    assign sh_data     = sh_data_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Bench for shift_issue_ctrl: directed scenarios plus randomized ops against a behavioural shifter/reference model.
module tb_shift_issue_ctrl;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_ctrl = '0;
    logic [2:0] req_amt = '0;
    logic [7:0] req_data = '0;
    logic       sh_start;
    logic [1:0] sh_ctrl;
    logic [2:0] sh_amt;
    logic [7:0] sh_data;
    logic [7:0] sh_result = '0;
    logic       sh_done = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;
    logic [7:0] op_count;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_cnt = '0;
    int         mdl_cnt = 0;
    int         mdl_dly = 1;
    bit         mdl_early = 1'b0;
    logic [7:0] mdl_res = '0;
    logic [7:0] got;

    shift_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_amt(req_amt), .req_data(req_data),
        .sh_start(sh_start), .sh_ctrl(sh_ctrl), .sh_amt(sh_amt), .sh_data(sh_data),
        .sh_result(sh_result), .sh_done(sh_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
        logic signed [7:0] s;
        logic [15:0]       dd;
        s  = d;
        dd = {d, d} >> a;
        case (c)
            2'd0:    return d << a;
            2'd1:    return d >> a;
            2'd2:    return s >>> a;
            default: return dd[7:0];
        endcase
    endfunction

    // Shifter model: done pulses mdl_dly cycles after start; result is junk on other cycles.
    always @(negedge clk) begin
        sh_done   = 1'b0;
        sh_result = 8'($urandom);
        if (!rst) begin
            mdl_cnt = 0;
        end else begin
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    sh_done   = 1'b1;
                    sh_result = mdl_res;
                end
            end
            if (sh_start) begin
                if (mdl_dly > 0) begin
                    mdl_cnt = mdl_dly;
                    mdl_res = ref_shift(sh_ctrl, sh_amt, sh_data);
                end
                if (mdl_early) begin
                    sh_done   = 1'b1;
                    sh_result = 8'hEE;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one op from IDLE (at a negedge) to back in IDLE. dly<0 means the shifter never answers.
    task automatic do_op(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d,
                         input int dly, input int bp, input bit early, output logic [7:0] res);
        bit         to;
        int         wc;
        int         n;
        int         starts;
        logic [7:0] exp;
        to  = (dly < 0) || (dly > TIMEOUT);
        wc  = to ? TIMEOUT : dly;
        exp = to ? d : ref_shift(c, a, d);
        mdl_dly   = dly;
        mdl_early = early;
        req_ctrl = c; req_amt = a; req_data = d; req_valid = 1'b1;
        chk("idle_ready", req_ready, 1);
        @(negedge clk);
        chk("issue_start", sh_start, 1);
        chk("issue_ready", req_ready, 0);
        chk("issue_busy", busy, 1);
        chk("issue_op", {sh_ctrl, sh_amt, sh_data}, {c, a, d});
        // Competing request with different operands while busy must be ignored.
        req_ctrl = ~c; req_amt = ~a; req_data = ~d;
        n = 0;
        starts = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
            starts += int'(sh_start);
        end
        chk("resp_latency", n, wc + 1);
        chk("extra_start", starts, 0);
        chk("resp_data", rsp_data, exp);
        chk("resp_timeout", rsp_timeout, to);
        chk("op_held", {sh_ctrl, sh_amt, sh_data}, {c, a, d});
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, exp);
            chk("bp_ready", req_ready, 0);
        end
        res = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        mdl_early = 1'b0;
        exp_cnt++;
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        chk("op_count", op_count, exp_cnt);
        chk("post_op", {sh_ctrl, sh_amt, sh_data}, {c, a, d});
    endtask

    initial begin
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", sh_start, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_regs", {sh_ctrl, sh_amt, sh_data, rsp_data, rsp_timeout, op_count}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(2'd0, 3'd1, 8'hB3, 3, 0, 0, got);
        chk("sll1", got, 8'h66);
        do_op(2'd2, 3'd3, 8'hB3, 2, 0, 0, got);
        chk("sra3", got, 8'hF6);
        do_op(2'd3, 3'd4, 8'hB3, 1, 0, 0, got);
        chk("ror4", got, 8'h3B);
        do_op(2'd1, 3'd2, 8'h81, 4, 5, 0, got);
        chk("srl2_bp", got, 8'h20);
        do_op(2'd1, 3'd3, 8'h5A, -1, 0, 0, got);
        chk("timeout_data", got, 8'h5A);
        do_op(2'd0, 3'd2, 8'h0F, TIMEOUT, 0, 0, got);
        chk("done_wins", got, 8'h3C);
        do_op(2'd0, 3'd2, 8'h0F, TIMEOUT + 1, 0, 0, got);
        chk("late_done", got, 8'h0F);
        do_op(2'd3, 3'd1, 8'h01, 2, 0, 1, got);
        chk("issue_done_ignored", got, 8'h80);

        // Asynchronous reset in the middle of WAIT.
        mdl_dly = -1;
        req_ctrl = 2'd2; req_amt = 3'd5; req_data = 8'hC3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", sh_start, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_op", {sh_ctrl, sh_amt, sh_data}, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        do_op(2'd0, 3'd0, 8'hAA, 2, 0, 0, got);
        chk("amt0_data", got, 8'hAA);
        chk("amt0_count", op_count, 1);

        for (int k = 0; k < 255; k++) begin
            int dly;
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TIMEOUT));
            do_op(2'($urandom), 3'($urandom), 8'($urandom), dly, int'($urandom_range(0, 2)), 0, got);
        end
        chk("count_wrap", op_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
